// File: rtl/coef_packer.sv
// rtl/coef_packer.sv - packs one subgraph of per-node coefficients into a single softmax word
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   coef_valid_i     input beat valid
//   coef_ready_o     input beat accepted when coef_valid_i & coef_ready_o
//   coef_i           coefficient of the current node
//   num_of_nodes_i   subgraph node count, sampled on the first beat only
//   sm_valid_o       packed word valid
//   sm_ready_i       softmax stage accepts word
//   sm_data_o        {coef_vec, num_of_nodes}; node k at [NUM_NODE_WIDTH + k*DATA_WIDTH +: DATA_WIDTH]
//   sg_cnt_o         completed output handshakes, wraps
//   err_o            one-cycle pulse after a first beat with an illegal node count

module coef_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_NODES      = 18,
    parameter int NUM_NODE_WIDTH = 5,
    parameter int SG_CNT_W       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      coef_valid_i,
    output logic                                      coef_ready_o,
    input  logic [DATA_WIDTH-1:0]                     coef_i,
    input  logic [NUM_NODE_WIDTH-1:0]                 num_of_nodes_i,
    output logic                                      sm_valid_o,
    input  logic                                      sm_ready_i,
    output logic [MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH-1:0] sm_data_o,
    output logic [SG_CNT_W-1:0]                       sg_cnt_o,
    output logic                                      err_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam logic [NUM_NODE_WIDTH-1:0] N_ONE = NUM_NODE_WIDTH'(1);
    localparam logic [NUM_NODE_WIDTH-1:0] N_MAX = NUM_NODE_WIDTH'(MAX_NODES);

    logic [1:0]                state;
    logic [NUM_NODE_WIDTH-1:0] n_q;
    logic [NUM_NODE_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0]     coef_buf [MAX_NODES];

    logic beat_acc;
    logic count_illegal;
    logic last_beat;

    // Ready is low only while a finished word waits for the softmax stage,
    // which forces at least one idle input cycle between subgraphs.
    assign coef_ready_o  = (state != ST_OUTPUT);
    assign sm_valid_o    = (state == ST_OUTPUT);
    assign beat_acc      = coef_valid_i & coef_ready_o;
    assign count_illegal = (num_of_nodes_i == '0) || (num_of_nodes_i > N_MAX);
    assign last_beat     = (idx == n_q - N_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            n_q      <= '0;
            idx      <= '0;
            sg_cnt_o <= '0;
            err_o    <= 1'b0;
            for (int k = 0; k < MAX_NODES; k++) begin
                coef_buf[k] <= '0;
            end
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (beat_acc) begin
                        // Every new subgraph starts from an all-zero vector so
                        // unused slots never carry data from an earlier word.
                        for (int k = 0; k < MAX_NODES; k++) begin
                            coef_buf[k] <= '0;
                        end
                        if (count_illegal) begin
                            err_o <= 1'b1;
                            n_q   <= '0;
                        end else begin
                            n_q         <= num_of_nodes_i;
                            coef_buf[0] <= coef_i;
                            idx         <= N_ONE;
                            state       <= (num_of_nodes_i == N_ONE) ? ST_OUTPUT : ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (beat_acc) begin
                        // Decoded write keeps the slot index in range for any idx value.
                        for (int k = 0; k < MAX_NODES; k++) begin
                            if (idx == NUM_NODE_WIDTH'(k)) begin
                                coef_buf[k] <= coef_i;
                            end
                        end
                        idx <= idx + N_ONE;
                        if (last_beat) begin
                            state <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (sm_ready_i) begin
                        sg_cnt_o <= sg_cnt_o + SG_CNT_W'(1);
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The word is a pure wiring of registers, so it is stable for as long as
    // the FSM sits in OUTPUT.
    always_comb begin
        sm_data_o                      = '0;
        sm_data_o[NUM_NODE_WIDTH-1:0]  = n_q;
        for (int k = 0; k < MAX_NODES; k++) begin
            sm_data_o[NUM_NODE_WIDTH + k*DATA_WIDTH +: DATA_WIDTH] = coef_buf[k];
        end
    end

endmodule

// File: tb/tb_coef_packer.sv
// tb/tb_coef_packer.sv - directed self-checking bench for coef_packer

module tb_coef_packer;

    localparam int DW    = 8;
    localparam int NN    = 18;
    localparam int NNW   = 5;
    localparam int SCW   = 16;
    localparam int DATAW = NN*DW + NNW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             coef_valid_i = 1'b0;
    logic             coef_ready_o;
    logic [DW-1:0]    coef_i = '0;
    logic [NNW-1:0]   num_of_nodes_i = '0;
    logic             sm_valid_o;
    logic             sm_ready_i = 1'b0;
    logic [DATAW-1:0] sm_data_o;
    logic [SCW-1:0]   sg_cnt_o;
    logic             err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_c [NN];

    coef_packer #(
        .DATA_WIDTH(DW),
        .MAX_NODES(NN),
        .NUM_NODE_WIDTH(NNW),
        .SG_CNT_W(SCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coef_valid_i(coef_valid_i),
        .coef_ready_o(coef_ready_o),
        .coef_i(coef_i),
        .num_of_nodes_i(num_of_nodes_i),
        .sm_valid_o(sm_valid_o),
        .sm_ready_i(sm_ready_i),
        .sm_data_o(sm_data_o),
        .sg_cnt_o(sg_cnt_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < NN; k++) exp_c[k] = '0;
    endtask

    function automatic logic [DATAW-1:0] pack_exp(input logic [NNW-1:0] n);
        logic [DATAW-1:0] w;
        w = '0;
        w[NNW-1:0] = n;
        for (int k = 0; k < NN; k++) w[NNW + k*DW +: DW] = exp_c[k];
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        coef_valid_i = 1'b0;
        sm_ready_i = 1'b0;
        coef_i = '0;
        num_of_nodes_i = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] c, input logic [NNW-1:0] n);
        coef_valid_i = 1'b1;
        coef_i = c;
        num_of_nodes_i = n;
        step();
        coef_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (coef_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", coef_ready_o); end
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", sm_valid_o); end
        tests_run++; if (sm_data_o !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", sm_data_o); end
        tests_run++; if (sg_cnt_o !== '0) begin tests_failed++; $display("FAIL reset_sg_cnt: got %0d expected 0", sg_cnt_o); end
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_o); end
    endtask

    task automatic test_basic_n3();
        logic [DATAW-1:0] w;
        do_reset();
        sm_ready_i = 1'b1;
        clear_exp();
        exp_c[0] = 8'h11; exp_c[1] = 8'h22; exp_c[2] = 8'h33;
        w = pack_exp(5'd3);
        send_beat(8'h11, 5'd3);
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL n3_early_valid: got %b expected 0", sm_valid_o); end
        send_beat(8'h22, 5'd7);
        send_beat(8'h33, 5'd7);
        tests_run++; if (sm_valid_o !== 1'b1) begin tests_failed++; $display("FAIL n3_valid: got %b expected 1", sm_valid_o); end
        tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL n3_data: got %h expected %h", sm_data_o, w); end
        tests_run++; if (coef_ready_o !== 1'b0) begin tests_failed++; $display("FAIL n3_ready_out: got %b expected 0", coef_ready_o); end
        step();
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL n3_valid_drop: got %b expected 0", sm_valid_o); end
        tests_run++; if (sg_cnt_o !== 16'd1) begin tests_failed++; $display("FAIL n3_sg_cnt: got %0d expected 1", sg_cnt_o); end
        tests_run++; if (coef_ready_o !== 1'b1) begin tests_failed++; $display("FAIL n3_ready_back: got %b expected 1", coef_ready_o); end
    endtask

    task automatic test_backpressure_n18();
        logic [DATAW-1:0] w;
        do_reset();
        clear_exp();
        for (int k = 0; k < NN; k++) exp_c[k] = 8'(k + 1);
        w = pack_exp(5'd18);
        for (int k = 0; k < NN; k++) send_beat(8'(k + 1), (k == 0) ? 5'd18 : 5'd2);
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (sm_valid_o !== 1'b1) begin tests_failed++; $display("FAIL n18_hold_valid c%0d: got %b expected 1", c, sm_valid_o); end
            tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL n18_hold_data c%0d: got %h expected %h", c, sm_data_o, w); end
            tests_run++; if (coef_ready_o !== 1'b0) begin tests_failed++; $display("FAIL n18_hold_ready c%0d: got %b expected 0", c, coef_ready_o); end
            step();
        end
        sm_ready_i = 1'b1;
        step();
        sm_ready_i = 1'b0;
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL n18_valid_drop: got %b expected 0", sm_valid_o); end
        tests_run++; if (coef_ready_o !== 1'b1) begin tests_failed++; $display("FAIL n18_ready_back: got %b expected 1", coef_ready_o); end
        tests_run++; if (sg_cnt_o !== 16'd1) begin tests_failed++; $display("FAIL n18_sg_cnt: got %0d expected 1", sg_cnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]    vals [4];
        logic [DATAW-1:0] w;
        logic             rdy;
        int               acc;
        int               words;
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4;
        acc = 0;
        words = 0;
        do_reset();
        sm_ready_i = 1'b1;
        coef_valid_i = 1'b1;
        num_of_nodes_i = 5'd1;
        for (int c = 0; c < 8; c++) begin
            coef_i = vals[(acc < 4) ? acc : 3];
            rdy = coef_ready_o;
            tests_run++; if (rdy !== ((c % 2) == 0)) begin tests_failed++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, rdy, ((c % 2) == 0)); end
            tests_run++; if (sm_valid_o !== ((c % 2) == 1)) begin tests_failed++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, sm_valid_o, ((c % 2) == 1)); end
            if (sm_valid_o === 1'b1 && words < 4) begin
                clear_exp();
                exp_c[0] = vals[words];
                w = pack_exp(5'd1);
                tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL b2b_data w%0d: got %h expected %h", words, sm_data_o, w); end
                words++;
            end
            step();
            if (rdy === 1'b1) acc++;
        end
        coef_valid_i = 1'b0;
        tests_run++; if (words !== 4) begin tests_failed++; $display("FAIL b2b_words: got %0d expected 4", words); end
        tests_run++; if (sg_cnt_o !== 16'd4) begin tests_failed++; $display("FAIL b2b_sg_cnt: got %0d expected 4", sg_cnt_o); end
    endtask

    task automatic test_illegal();
        logic [DATAW-1:0] w;
        do_reset();
        send_beat(8'h55, 5'd0);
        tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_n0_err: got %b expected 1", err_o); end
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ill_n0_valid: got %b expected 0", sm_valid_o); end
        tests_run++; if (coef_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ill_n0_ready: got %b expected 1", coef_ready_o); end
        step();
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_err_pulse: got %b expected 0", err_o); end
        send_beat(8'h66, 5'd20);
        tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_n20_err: got %b expected 1", err_o); end
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ill_n20_valid: got %b expected 0", sm_valid_o); end
        clear_exp();
        exp_c[0] = 8'hAA; exp_c[1] = 8'hBB;
        w = pack_exp(5'd2);
        send_beat(8'hAA, 5'd2);
        send_beat(8'hBB, 5'd2);
        tests_run++; if (sm_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ill_n2_valid: got %b expected 1", sm_valid_o); end
        tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL ill_n2_data: got %h expected %h", sm_data_o, w); end
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_n2_err: got %b expected 0", err_o); end
        tests_run++; if (sg_cnt_o !== 16'd0) begin tests_failed++; $display("FAIL ill_sg_cnt: got %0d expected 0", sg_cnt_o); end
    endtask

    task automatic test_reset_mid();
        logic [DATAW-1:0] w;
        do_reset();
        sm_ready_i = 1'b1;
        send_beat(8'h77, 5'd1);
        step();
        tests_run++; if (sg_cnt_o !== 16'd1) begin tests_failed++; $display("FAIL rmid_pre_cnt: got %0d expected 1", sg_cnt_o); end
        sm_ready_i = 1'b0;
        send_beat(8'h0A, 5'd5);
        send_beat(8'h0B, 5'd5);
        rst = 1'b1;
        step();
        tests_run++; if (coef_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready: got %b expected 1", coef_ready_o); end
        tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b expected 0", sm_valid_o); end
        tests_run++; if (sm_data_o !== '0) begin tests_failed++; $display("FAIL rmid_data: got %h expected 0", sm_data_o); end
        tests_run++; if (sg_cnt_o !== 16'd0) begin tests_failed++; $display("FAIL rmid_sg_cnt: got %0d expected 0", sg_cnt_o); end
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_err: got %b expected 0", err_o); end
        rst = 1'b0;
        clear_exp();
        exp_c[0] = 8'h01; exp_c[1] = 8'h02;
        w = pack_exp(5'd2);
        send_beat(8'h01, 5'd2);
        send_beat(8'h02, 5'd2);
        tests_run++; if (sm_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_n2_valid: got %b expected 1", sm_valid_o); end
        tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL rmid_n2_data: got %h expected %h", sm_data_o, w); end
    endtask

    task automatic test_bubbles();
        logic [DW-1:0]    vals [4];
        logic [DATAW-1:0] w;
        int unsigned      nb;
        vals[0] = 8'h3C; vals[1] = 8'h5A; vals[2] = 8'h96; vals[3] = 8'hF0;
        clear_exp();
        for (int k = 0; k < 4; k++) exp_c[k] = vals[k];
        w = pack_exp(5'd4);
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int b = 0; b < 4; b++) begin
                nb = (run == 0) ? 0 : $urandom_range(0, 2);
                for (int g = 0; g < int'(nb); g++) begin
                    coef_valid_i = 1'b0;
                    coef_i = 8'hEE;
                    num_of_nodes_i = 5'd9;
                    step();
                    tests_run++; if (sm_valid_o !== 1'b0) begin tests_failed++; $display("FAIL bub_early_valid b%0d: got %b expected 0", b, sm_valid_o); end
                end
                send_beat(vals[b], (b == 0) ? 5'd4 : 5'd9);
            end
            tests_run++; if (sm_valid_o !== 1'b1) begin tests_failed++; $display("FAIL bub_valid run%0d: got %b expected 1", run, sm_valid_o); end
            tests_run++; if (sm_data_o !== w) begin tests_failed++; $display("FAIL bub_data run%0d: got %h expected %h", run, sm_data_o, w); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_n3();
        test_backpressure_n18();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
